// File: rtl/i2c_slave_responder.sv
// ---------------------------------------------------------------------------
// i2c_slave_responder
//
// I2C target that serves a small internal register file. SCL/SDA are
// oversampled on pclk; START, STOP and repeated START are recognised in any
// state. A write carries one register-address byte followed by data bytes,
// which are stored at an auto-incrementing pointer. A read streams bytes
// from the current pointer until the master NACKs.
//
// Optional feature (compile-time macro I2C_SLAVE_GENERAL_CALL_EN):
//   When defined, general-call address 7'h00 (write) is ACKed. A following
//   byte 8'h06 is ACKed and clears the register file and the pointer. Any
//   other byte is NACKed. When undefined, 7'h00 is an ordinary mismatch.
//
// Ports
//   pclk      system clock, at least 8x SCL
//   areset    asynchronous active-low reset
//   scl_i     SCL bus level (asynchronous)
//   sda_i     SDA bus level (asynchronous)
//   sda_oe    1 = pull SDA low, 0 = release
//   busy      high from START to STOP, for any address
//   wr_valid  one-cycle pulse per written data byte
//   wr_addr   register index of that write
//   wr_data   byte written
//   rd_nack   one-cycle pulse when the master NACKs a read byte
// ---------------------------------------------------------------------------
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NO_OF_REG  = 4,
  parameter int         DATA_WIDTH = 8,
  parameter bit         MSB_FIRST  = 1'b1
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic                  busy,
  output logic                  wr_valid,
  output logic [7:0]            wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_nack
);

  localparam int PTR_W = (NO_OF_REG > 1) ? $clog2(NO_OF_REG) : 1;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_REG       = 4'd3;
  localparam logic [3:0] ST_REG_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RACK      = 4'd8;
  localparam logic [3:0] ST_IGNORE    = 4'd9;

  // -------------------------------------------------------------------------
  // Input conditioning: two synchronizer flops plus one history flop per line.
  // Flops reset to 1 (idle bus level) so reset release never fakes a START.
  // -------------------------------------------------------------------------
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the flop chain shift one stage per
      // clock; blocking ones would collapse it into a single flop.
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_evt, stop_evt;
  assign scl_rise  =  scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 &  scl_d;
  assign start_evt =  scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_evt  =  scl_s2 & scl_d & ~sda_d & sda_s2;

  // -------------------------------------------------------------------------
  // Protocol state
  // -------------------------------------------------------------------------
  logic [3:0]            state;
  logic [2:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic [PTR_W-1:0]      ptr;
  logic                  rw;
  // In the *_ACK states: 0 = waiting for the fall after bit 8, 1 = ACK driven.
  // In RACK: 1 = SDA release still pending on the next fall.
  logic                  ack_phase;
  logic [DATA_WIDTH-1:0] regs [NO_OF_REG];
`ifdef I2C_SLAVE_GENERAL_CALL_EN
  logic                  gc;
`endif

  // Byte as it would stand after shifting in the current SDA sample.
  logic [DATA_WIDTH-1:0] rx_msb, rx_data;
  assign rx_msb  = {shift[DATA_WIDTH-2:0], sda_s2};
  assign rx_data = MSB_FIRST ? rx_msb : {sda_s2, shift[DATA_WIDTH-1:1]};

  logic [PTR_W-1:0] ptr_inc, reg_idx;
  assign ptr_inc = (NO_OF_REG == 1) ? '0 : ptr + 1'b1;
  assign reg_idx = (NO_OF_REG == 1) ? '0 : rx_msb[PTR_W-1:0];

  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_first, tx_bit;
  assign rd_word  = regs[ptr];
  assign rd_first = MSB_FIRST ? rd_word[DATA_WIDTH-1] : rd_word[0];
  assign tx_bit   = MSB_FIRST ? shift[DATA_WIDTH-1]   : shift[0];

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_nack   <= 1'b0;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
      gc        <= 1'b0;
`endif
      // NOTE: the register file is part of the architectural reset state
      // (software expects zeros after reset), so it is cleared here rather
      // than left as an unreset RAM.
      for (int i = 0; i < NO_OF_REG; i++) regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      rd_nack  <= 1'b0;

      if (start_evt) begin
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        gc        <= 1'b0;
`endif
      end else if (stop_evt) begin
        // A partial byte is simply abandoned: nothing is written, ptr holds.
        state     <= ST_IDLE;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shift   <= rx_msb;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw <= rx_msb[0];
                if (rx_msb[7:1] == SLAVE_ADDR) begin
                  state <= ST_ADDR_ACK;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
                end else if (rx_msb == 8'h00) begin
                  gc    <= 1'b1;
                  state <= ST_ADDR_ACK;
`endif
                end else begin
                  state <= ST_IGNORE;
                end
              end
            end
          end

          ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                sda_oe    <= 1'b0;
                if (state == ST_ADDR_ACK) begin
                  if (rw) begin
                    // First read bit goes out on this same falling edge.
                    shift  <= rd_word;
                    sda_oe <= ~rd_first;
                    state  <= ST_RDATA;
                  end else begin
                    state <= ST_REG;
                  end
                end else if (state == ST_REG_ACK) begin
`ifdef I2C_SLAVE_GENERAL_CALL_EN
                  state <= gc ? ST_IGNORE : ST_WDATA;
`else
                  state <= ST_WDATA;
`endif
                end else begin
                  state <= ST_WDATA;
                end
              end
            end
          end

          ST_REG: begin
            if (scl_rise) begin
              shift   <= rx_msb;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef I2C_SLAVE_GENERAL_CALL_EN
                if (gc) begin
                  if (rx_msb == 8'h06) begin
                    for (int i = 0; i < NO_OF_REG; i++) regs[i] <= '0;
                    ptr   <= '0;
                    state <= ST_REG_ACK;
                  end else begin
                    state <= ST_IGNORE;
                  end
                end else begin
                  ptr   <= reg_idx;
                  state <= ST_REG_ACK;
                end
`else
                ptr   <= reg_idx;
                state <= ST_REG_ACK;
`endif
              end
            end
          end

          ST_WDATA: begin
            if (scl_rise) begin
              shift   <= rx_data;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                regs[ptr] <= rx_data;
                wr_valid  <= 1'b1;
                wr_addr   <= 8'(ptr);
                wr_data   <= rx_data;
                ptr       <= ptr_inc;
                state     <= ST_WDATA_ACK;
              end
            end
          end

          ST_RDATA: begin
            if (scl_fall) begin
              sda_oe <= ~tx_bit;
            end else if (scl_rise) begin
              shift   <= MSB_FIRST ? {shift[DATA_WIDTH-2:0], 1'b0}
                                   : {1'b0, shift[DATA_WIDTH-1:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ack_phase <= 1'b1;
                state     <= ST_RACK;
              end
            end
          end

          ST_RACK: begin
            if (scl_fall && ack_phase) begin
              sda_oe    <= 1'b0;
              ptr       <= ptr_inc;
              ack_phase <= 1'b0;
            end else if (scl_rise && !ack_phase) begin
              if (!sda_s2) begin
                shift   <= rd_word;
                bit_cnt <= '0;
                state   <= ST_RDATA;
              end else begin
                rd_nack <= 1'b1;
                state   <= ST_IGNORE;
              end
            end
          end

          default: begin
            // IDLE and IGNORE: hands off the bus until START or STOP.
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
